seg7_digit_sequencer: RTL
=========================

// Module: seg7_digit_sequencer
// PURPOSE
//  Upstream feeder for the seven-segment nibble decoder.
//  Accepts a multi-nibble value through a valid/ready load port.
//  Presents the value one hex nibble at a time, most significant first, on the
//  single display. Each nibble is held for a dwell period, then a blank gap follows.
//  Optional leading-zero suppression and continuous repeat.
//  digit drives the decoder input. digit_valid gates the segments (low = blank).
// PARAMETERS
//  NUM_DIGITS   4      nibbles per load; load_data width = 4*NUM_DIGITS
//  DWELL_CYCLES 1000   clk cycles each nibble is shown (>=1)
//  GAP_CYCLES   250    blank clk cycles after each nibble (0 = no gap state)
//  LZ_SUPPRESS  1      1: skip leading zero nibbles (nibble 0 always shown)
//  REPEAT       0      1: restart sequence after last nibble instead of idling
// PORTS
//  clk         in   1        system clock
//  rst         in   1        synchronous reset, active-high
//  load_valid  in   1        load_data is valid
//  load_ready  out  1        block can accept a load this cycle
//  load_data   in   4*NUM_DIGITS  value; nibble i = load_data[4i+3:4i]
//  digit       out  4        nibble to decoder
//  digit_valid out  1        1 = display digit, 0 = blank
//  digit_last  out  1        1 while nibble index 0 is shown (decimal point)
//  done        out  1        one-cycle pulse at end of a pass
// BEHAVIOUR
//  Reset values:
//   - state IDLE, digit=0, digit_valid=0, digit_last=0, done=0
//   - load_ready=1, internal value and counters cleared
//  Reset mid-sequence takes effect at the next edge; the sequence is abandoned, no done pulse.
//  States: IDLE, SHOW, GAP.
//  load_ready = (state==IDLE) | REPEAT. A load is accepted when load_valid & load_ready are both high at an edge.
//  Accept at edge t:
//   - value is registered.
//   - start index s = highest nonzero nibble index when LZ_SUPPRESS, else NUM_DIGITS-1.
//   - An all-zero value gives s = 0.
//   - state=SHOW, idx=s, timer cleared. digit is valid from cycle t+1 (1-cycle latency).
//  A load accepted while busy (REPEAT=1 only) restarts the sequence from the new value. No done pulse is issued for the aborted pass.
//  SHOW:
//   - digit = value nibble idx, digit_valid=1, digit_last=(idx==0).
//   - Lasts exactly DWELL_CYCLES cycles, then goes to GAP. If GAP_CYCLES==0 it applies the GAP exit rule directly.
//  GAP:
//   - digit_valid=0, digit_last=0; digit holds its last value.
//   - Lasts exactly GAP_CYCLES cycles.
//   - Exit with idx>0: idx-1, go to SHOW.
//   - Exit with idx==0: done=1 for one cycle (registered, same edge as the transition).
//   - Then REPEAT ? (idx=s, SHOW) : IDLE.
//  Pass length = (s+1)*(DWELL_CYCLES+GAP_CYCLES) cycles.
//  Timer is a single down/up counter of width $clog2(max(DWELL,GAP)+1). It reloads on every state entry. There is no wrap beyond the terminal count.
//  In IDLE, digit_valid=0 and digit_last=0; digit holds its last value.
//  load_valid while load_ready=0 is ignored. Data is not queued.
// STRUCTURE
//  Shared package seg7_pkg:
//   - state encodings IDLE/SHOW/GAP
//   - NIBBLE_W=4
//   - BLANK convention (digit_valid=0)
//  Sub-module nibble_lz_finder (combinational): load_data -> start index s, width $clog2(NUM_DIGITS).
//  The decoder is instantiated by the parent, not in this block.
// TESTING  (NUM_DIGITS=4, DWELL_CYCLES=4, GAP_CYCLES=2 unless noted)
//  1. LZ=0, load 16'h1A2F:
//     digits 1,A,2,F each valid 4 cycles followed by 2 blank cycles.
//     digit_last only during F. done at cycle 24 after accept. Then IDLE, load_ready=1.
//  2. LZ=1, load 16'h003C: only 3 then C shown, done after 12 cycles.
//     Load 16'h0000: single 0 shown with digit_last=1, done after 6 cycles.
//  3. REPEAT=0, load 16'h1234, then assert load_valid with 16'hFFFF mid-pass:
//     load_ready=0 and the load is ignored. Sequence 1,2,3,4 is unchanged.
//  4. REPEAT=1, load 16'h00AB (LZ=1): A,B,A,B... with done every 12 cycles.
//     New load 16'h0005 mid-SHOW restarts the next cycle showing 5.
//  5. Assert rst during SHOW of second nibble:
//     next cycle all outputs are at reset values, no done pulse.
//     A new load works normally.
//  6. GAP_CYCLES=0, load 16'h1234 (LZ=0):
//     digit_valid stays 1 for 16 cycles, digit changes every 4. done at cycle 16.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment digit sequencer.
// Provides state encodings, nibble width, blank level and sizing helpers.
package seg7_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SHOW = 2'd1,
      ST_GAP  = 2'd2
   } seq_state_t;

   localparam int NIBBLE_W = 4;

   // Level of digit_valid that blanks the segments.
   localparam logic BLANK = 1'b0;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Index width that never collapses to zero bits.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/nibble_lz_finder.sv
// Combinational start-index finder for the digit sequencer.
// Ports: i_data (packed nibbles) -> o_start (first nibble index to show).
module nibble_lz_finder
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter bit LZ_SUPPRESS = 1'b1
) (
   input  logic [NUM_DIGITS*NIBBLE_W-1:0]   i_data,
   output logic [idx_width(NUM_DIGITS)-1:0] o_start
);

   localparam int IW = idx_width(NUM_DIGITS);

   // Highest nonzero nibble wins; an all-zero value leaves index 0.
   always_comb begin
      o_start = '0;
      if (LZ_SUPPRESS) begin
         for (int i = 1; i < NUM_DIGITS; i++) begin
            if (i_data[i*NIBBLE_W +: NIBBLE_W] != '0) begin
               o_start = IW'(i);
            end
         end
      end else begin
         o_start = IW'(NUM_DIGITS - 1);
      end
   end

endmodule

// File: rtl/seg7_digit_sequencer.sv
// Feeds a seven-segment nibble decoder one hex digit at a time, MSB first.
// Ports: i_clk, i_rst (sync, active-high), i_load_valid/o_load_ready/
// i_load_data load port, o_digit, o_digit_valid, o_digit_last, o_done.
module seg7_digit_sequencer
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int DWELL_CYCLES = 1000,
   parameter int GAP_CYCLES   = 250,
   parameter bit LZ_SUPPRESS  = 1'b1,
   parameter bit REPEAT       = 1'b0
) (
   input  logic                           i_clk,
   input  logic                           i_rst,
   input  logic                           i_load_valid,
   output logic                           o_load_ready,
   input  logic [NUM_DIGITS*NIBBLE_W-1:0] i_load_data,
   output logic [NIBBLE_W-1:0]            o_digit,
   output logic                           o_digit_valid,
   output logic                           o_digit_last,
   output logic                           o_done
);

   localparam int DW = NUM_DIGITS * NIBBLE_W;
   localparam int IW = idx_width(NUM_DIGITS);
   localparam int TW = $clog2(max_int(DWELL_CYCLES, GAP_CYCLES) + 1);
   localparam bit HAS_GAP = (GAP_CYCLES > 0);

   localparam logic [TW-1:0] DW_LAST = TW'(DWELL_CYCLES - 1);
   localparam logic [TW-1:0] GP_LAST =
      TW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   seq_state_t          r_state;
   logic [DW-1:0]       r_value;
   logic [IW-1:0]       r_start;
   logic [IW-1:0]       r_idx;
   logic [TW-1:0]       r_timer;
   logic [NIBBLE_W-1:0] r_digit;
   logic                r_valid;
   logic                r_last;
   logic                r_done;

   logic [IW-1:0]       w_start;
   logic [IW-1:0]       w_next_idx;
   logic [NIBBLE_W-1:0] w_load_nib;
   logic [NIBBLE_W-1:0] w_step_nib;
   logic [NIBBLE_W-1:0] w_rpt_nib;
   logic                w_load_ready;
   logic                w_accept;
   logic                w_show_end;
   logic                w_gap_end;
   logic                w_step;

   function automatic logic [NIBBLE_W-1:0] nib_at(
      input logic [DW-1:0] v,
      input logic [IW-1:0] i
   );
      logic [NIBBLE_W-1:0] n;
      n = '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (IW'(k) == i) n = v[k*NIBBLE_W +: NIBBLE_W];
      end
      return n;
   endfunction

   nibble_lz_finder #(
      .NUM_DIGITS  (NUM_DIGITS),
      .LZ_SUPPRESS (LZ_SUPPRESS)
   ) u_lz (
      .i_data  (i_load_data),
      .o_start (w_start)
   );

   assign w_load_ready = (r_state == ST_IDLE) || REPEAT;
   assign w_accept     = i_load_valid && w_load_ready;
   assign w_show_end   = (r_state == ST_SHOW) && (r_timer == DW_LAST);
   assign w_gap_end    = (r_state == ST_GAP) && (r_timer == GP_LAST);
   // Without a gap the end of SHOW is itself the step to the next nibble.
   assign w_step       = (w_show_end && !HAS_GAP) || w_gap_end;
   assign w_next_idx   = r_idx - IW'(1);
   assign w_load_nib   = nib_at(i_load_data, w_start);
   assign w_step_nib   = nib_at(r_value, w_next_idx);
   assign w_rpt_nib    = nib_at(r_value, r_start);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
         r_value <= '0;
         r_start <= '0;
         r_idx   <= '0;
         r_timer <= '0;
         r_digit <= '0;
         r_valid <= BLANK;
         r_last  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         // A new load overrides any pass in flight; that pass gets no done.
         if (w_accept) begin
            r_state <= ST_SHOW;
            r_value <= i_load_data;
            r_start <= w_start;
            r_idx   <= w_start;
            r_timer <= '0;
            r_digit <= w_load_nib;
            r_valid <= 1'b1;
            r_last  <= (w_start == '0);
         end else if (w_step) begin
            r_timer <= '0;
            if (r_idx != '0) begin
               r_state <= ST_SHOW;
               r_idx   <= w_next_idx;
               r_digit <= w_step_nib;
               r_valid <= 1'b1;
               r_last  <= (w_next_idx == '0);
            end else begin
               r_done <= 1'b1;
               if (REPEAT) begin
                  r_state <= ST_SHOW;
                  r_idx   <= r_start;
                  r_digit <= w_rpt_nib;
                  r_valid <= 1'b1;
                  r_last  <= (r_start == '0);
               end else begin
                  r_state <= ST_IDLE;
                  r_valid <= BLANK;
                  r_last  <= 1'b0;
               end
            end
         end else if (w_show_end) begin
            r_state <= ST_GAP;
            r_timer <= '0;
            r_valid <= BLANK;
            r_last  <= 1'b0;
         end else if (r_state != ST_IDLE) begin
            r_timer <= r_timer + TW'(1);
         end
      end
   end

   assign o_load_ready  = w_load_ready;
   assign o_digit       = r_digit;
   assign o_digit_valid = r_valid;
   assign o_digit_last  = r_last;
   assign o_done        = r_done;

endmodule
